pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_entry_reg.sv | 25 ++
 rtl/pipe_stage_reg.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: default field widths,
// the entry record layout and a helper giving the packed entry width.
package pipe_pkg;

    localparam int PC_W_DEF    = 16;
    localparam int INSTR_W_DEF = 16;
    localparam int SIDE_W_MAX  = 8;

    // Field order here is the packing order used for every stored entry.
    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [PC_W_DEF-1:0]    pc_next;
        logic [INSTR_W_DEF-1:0] instr;
        logic [SIDE_W_MAX-1:0]  side;
    } entry_t;

    function automatic int entry_width(input int pc_w, input int instr_w, input int side_w);
        return 2 * pc_w + instr_w + side_w;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Load-enabled record register that clears to zero on reset; the single
// storage element used for both the head and skid slots.
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Fetch/decode pipeline stage: either a two-entry elastic (skid) stage with a
// registered in_ready, or a single-entry register whose in_ready follows out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int SIDE_W  = 1,
    parameter int SKID_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [PC_W-1:0]    in_pc_next,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [SIDE_W-1:0]  in_side,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_pc_next,
    output logic [INSTR_W-1:0] out_instr,
    output logic [SIDE_W-1:0]  out_side,
    output logic [1:0]         count
);

    localparam int ENTRY_W = entry_width(PC_W, INSTR_W, SIDE_W);

    logic [ENTRY_W-1:0] w_in_entry;
    logic [ENTRY_W-1:0] w_head_q;
    logic [1:0]         r_count;

    assign w_in_entry = {in_pc, in_pc_next, in_instr, in_side};
    assign {out_pc, out_pc_next, out_instr, out_side} = w_head_q;
    assign out_valid  = (r_count != 2'd0);
    assign count      = r_count;

    if (SKID_EN != 0) begin : g_skid
        logic               r_in_ready;
        logic               w_accept;
        logic               w_release;
        logic               w_head_load;
        logic               w_skid_load;
        logic [ENTRY_W-1:0] w_head_d;
        logic [ENTRY_W-1:0] w_skid_q;
        logic [1:0]         w_count_next;

        always_comb begin
            w_accept     = in_valid && r_in_ready && !flush;
            w_release    = (r_count != 2'd0) && out_ready && !flush;
            w_head_load  = 1'b0;
            w_skid_load  = 1'b0;
            w_head_d     = w_in_entry;
            w_count_next = r_count;
            if (flush) begin
                w_count_next = 2'd0;
            end else begin
                case (r_count)
                    2'd0: begin
                        if (w_accept) begin
                            w_head_load  = 1'b1;
                            w_count_next = 2'd1;
                        end
                    end
                    2'd1: begin
                        // Simultaneous accept and release replaces the head in place.
                        if (w_accept && w_release) begin
                            w_head_load = 1'b1;
                        end else if (w_accept) begin
                            w_skid_load  = 1'b1;
                            w_count_next = 2'd2;
                        end else if (w_release) begin
                            w_count_next = 2'd0;
                        end
                    end
                    default: begin
                        if (w_release) begin
                            w_head_d     = w_skid_q;
                            w_head_load  = 1'b1;
                            w_count_next = 2'd1;
                        end
                    end
                endcase
            end
        end

        // in_ready is computed from the next occupancy so it never depends on out_ready combinationally.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_count    <= 2'd0;
                r_in_ready <= 1'b1;
            end else begin
                r_count    <= w_count_next;
                r_in_ready <= (w_count_next != 2'd2);
            end
        end

        assign in_ready = r_in_ready;

        pipe_entry_reg #(.W(ENTRY_W)) u_head (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_head_load),
            .i_d    (w_head_d),
            .o_q    (w_head_q)
        );

        pipe_entry_reg #(.W(ENTRY_W)) u_skid (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_skid_load),
            .i_d    (w_in_entry),
            .o_q    (w_skid_q)
        );
    end else begin : g_single
        logic w_in_ready;
        logic w_accept;
        logic w_release;

        assign w_in_ready = (r_count == 2'd0) || out_ready;
        assign w_accept   = in_valid && w_in_ready && !flush;
        assign w_release  = (r_count != 2'd0) && out_ready && !flush;
        assign in_ready   = w_in_ready;

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                r_count <= 2'd0;
            end else if (w_accept) begin
                r_count <= 2'd1;
            end else if (w_release) begin
                r_count <= 2'd0;
            end
        end

        pipe_entry_reg #(.W(ENTRY_W)) u_head (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_accept),
            .i_d    (w_in_entry),
            .o_q    (w_head_q)
        );
    end

endmodule
